// File: rtl/pulse_gen_array.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gen_array
// Purpose  : Multi-channel push-button conditioner: synchroniser, debounce and
//            registered edge / auto-repeat pulses under a shared mode and enable.
// Revision : 1.0  initial release
// ============================================================================
module pulse_gen_array #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250
) (
  input  logic            clk_d,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_raw,
  input  logic [1:0]      mode,
  input  logic            en,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_pulse,
  output logic            pb_any
);

  localparam int c_deb_w   = $clog2(DEB_CYCLES + 1);
  localparam int c_rpt_max = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int c_rpt_w   = $clog2(c_rpt_max);

  localparam logic [c_deb_w-1:0] c_deb_last  = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_deb_w-1:0] c_deb_one   = c_deb_w'(1);
  localparam logic [c_rpt_w-1:0] c_hold_last = c_rpt_w'(HOLD_CYCLES - 1);
  localparam logic [c_rpt_w-1:0] c_rep_last  = c_rpt_w'(REPEAT_CYCLES - 1);
  localparam logic [c_rpt_w-1:0] c_rpt_one   = c_rpt_w'(1);

  localparam logic [1:0] c_mode_rise = 2'b00;
  localparam logic [1:0] c_mode_fall = 2'b01;
  localparam logic [1:0] c_mode_both = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } rpt_state_t;

  logic [1:0] r_mode_q;
  logic       w_mode_chg;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) r_mode_q <= 2'b00;
    else        r_mode_q <= mode;
  end

  // A mode change drops every channel back to idle and suppresses that cycle's pulse.
  assign w_mode_chg = (mode != r_mode_q);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_deb_w-1:0]     r_deb_cnt;
    logic [c_deb_w-1:0]     w_deb_cnt_nxt;
    logic                   r_level;
    logic                   w_toggle;
    logic                   w_rise;
    logic                   w_fall;
    rpt_state_t             r_state;
    rpt_state_t             w_state_nxt;
    logic [c_rpt_w-1:0]     r_rpt_cnt;
    logic [c_rpt_w-1:0]     w_rpt_cnt_nxt;
    logic                   r_pulse;
    logic                   w_pulse_nxt;

    always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
        r_sync    <= '0;
        r_deb_cnt <= '0;
        r_level   <= 1'b0;
      end else begin
        r_sync    <= {r_sync[SYNC_STAGES-2:0], pb_raw[i]};
        r_deb_cnt <= w_deb_cnt_nxt;
        r_level   <= r_level ^ w_toggle;
      end
    end

    always_comb begin
      w_deb_cnt_nxt = '0;
      w_toggle      = 1'b0;
      if (r_sync[SYNC_STAGES-1] != r_level) begin
        if (r_deb_cnt == c_deb_last) w_toggle = 1'b1;
        else                         w_deb_cnt_nxt = r_deb_cnt + c_deb_one;
      end
    end

    assign w_rise = w_toggle & ~r_level;
    assign w_fall = w_toggle &  r_level;

    always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= ST_IDLE;
        r_rpt_cnt <= '0;
        r_pulse   <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_rpt_cnt <= w_rpt_cnt_nxt;
        r_pulse   <= w_pulse_nxt;
      end
    end

    // Defaults return to idle; only an active mode-11 press keeps the FSM alive.
    always_comb begin
      w_state_nxt   = ST_IDLE;
      w_rpt_cnt_nxt = '0;
      w_pulse_nxt   = 1'b0;
      if (en && !w_mode_chg) begin
        case (mode)
          c_mode_rise: w_pulse_nxt = w_rise;
          c_mode_fall: w_pulse_nxt = w_fall;
          c_mode_both: w_pulse_nxt = w_rise | w_fall;
          default: begin
            case (r_state)
              ST_IDLE: begin
                if (w_rise) begin
                  w_pulse_nxt = 1'b1;
                  w_state_nxt = ST_HOLD;
                end
              end
              ST_HOLD: begin
                if (!w_fall) begin
                  if (r_rpt_cnt == c_hold_last) begin
                    w_pulse_nxt = 1'b1;
                    w_state_nxt = ST_REPEAT;
                  end else begin
                    w_state_nxt   = ST_HOLD;
                    w_rpt_cnt_nxt = r_rpt_cnt + c_rpt_one;
                  end
                end
              end
              ST_REPEAT: begin
                if (!w_fall) begin
                  w_state_nxt = ST_REPEAT;
                  if (r_rpt_cnt == c_rep_last) w_pulse_nxt   = 1'b1;
                  else                         w_rpt_cnt_nxt = r_rpt_cnt + c_rpt_one;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end

    assign pb_level[i] = r_level;
    assign pb_pulse[i] = r_pulse;
  end

  assign pb_any = |pb_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_gen_array
// Purpose  : Self-checking bench for pulse_gen_array against a window/arithmetic
//            reference model, plus directed latency and pulse-timing checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_pulse_gen_array;

  localparam int N_CH          = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int DEB_CYCLES    = 4;
  localparam int HOLD_CYCLES   = 20;
  localparam int REPEAT_CYCLES = 5;
  // Negedge count, from the drive, at which an accepted level change is first seen.
  localparam int c_lat = SYNC_STAGES + DEB_CYCLES;

  logic            clk_d  = 1'b0;
  logic            rst_n  = 1'b0;
  logic [N_CH-1:0] pb_raw = '0;
  logic [1:0]      mode   = 2'b00;
  logic            en     = 1'b1;
  logic [N_CH-1:0] pb_level;
  logic [N_CH-1:0] pb_pulse;
  logic            pb_any;

  int n_checks = 0;
  int n_pass   = 0;

  pulse_gen_array #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk_d(clk_d), .rst_n(rst_n), .pb_raw(pb_raw), .mode(mode), .en(en),
    .pb_level(pb_level), .pb_pulse(pb_pulse), .pb_any(pb_any)
  );

  always #5 clk_d = ~clk_d;

  // Reference model: a level flips once the last DEB_CYCLES synced samples all disagree;
  // repeat pulses are computed from the distance to the arming press.
  logic [15:0]     m_hist [N_CH];
  logic [15:0]     n_hist [N_CH];
  int              m_arm  [N_CH];
  int              n_arm  [N_CH];
  logic [N_CH-1:0] m_level, m_pulse, n_level, n_pulse;
  logic [1:0]      m_mode_prev;
  int              m_cyc;
  bit              t_diff, t_rise, t_fall;
  int              t_d;

  always_comb begin : ref_next
    t_diff  = 1'b0;
    t_rise  = 1'b0;
    t_fall  = 1'b0;
    t_d     = 0;
    n_level = m_level;
    n_pulse = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      n_hist[ch] = {m_hist[ch][14:0], pb_raw[ch]};
      n_arm[ch]  = -1;
      t_diff     = 1'b1;
      for (int j = 1; j <= DEB_CYCLES; j++)
        if (m_hist[ch][j] == m_level[ch]) t_diff = 1'b0;
      t_rise = t_diff & ~m_level[ch];
      t_fall = t_diff &  m_level[ch];
      if (t_diff) n_level[ch] = ~m_level[ch];
      if (en && (mode == m_mode_prev)) begin
        case (mode)
          2'b00: n_pulse[ch] = t_rise;
          2'b01: n_pulse[ch] = t_fall;
          2'b10: n_pulse[ch] = t_rise | t_fall;
          default: begin
            if (t_rise) begin
              n_pulse[ch] = 1'b1;
              n_arm[ch]   = m_cyc;
            end else if (!t_fall && m_arm[ch] >= 0) begin
              n_arm[ch]   = m_arm[ch];
              t_d         = m_cyc - m_arm[ch];
              n_pulse[ch] = (t_d >= HOLD_CYCLES) && (((t_d - HOLD_CYCLES) % REPEAT_CYCLES) == 0);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_d or negedge rst_n) begin : ref_state
    if (!rst_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        m_hist[ch] <= '0;
        m_arm[ch]  <= -1;
      end
      m_level     <= '0;
      m_pulse     <= '0;
      m_mode_prev <= 2'b00;
      m_cyc       <= 0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        m_hist[ch] <= n_hist[ch];
        m_arm[ch]  <= n_arm[ch];
      end
      m_level     <= n_level;
      m_pulse     <= n_pulse;
      m_mode_prev <= mode;
      m_cyc       <= m_cyc + 1;
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    pb_raw = '0;
    mode   = 2'b00;
    en     = 1'b1;
    repeat (3) @(negedge clk_d);
    n_checks++;
    if (pb_level !== '0 || pb_pulse !== '0 || pb_any !== 1'b0)
      $display("FAIL reset_state level=%b pulse=%b any=%b expected all 0", pb_level, pb_pulse, pb_any);
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL reset_release c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    mode      = 2'b00;
    pb_raw[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level[0] !== 1'b0 || pb_pulse !== '0 || pb_level !== m_level || pb_pulse !== m_pulse)
        $display("FAIL glitch c=%0d level=%b pulse=%b expected level0=0 pulse=0", c, pb_level, pb_pulse);
      else n_pass++;
      if (c == 3) pb_raw[0] = 1'b0;
    end
  endtask

  task automatic test_press();
    int npulse = 0, pulse_at = -1, rise_at = -1, fall_at = -1;
    mode      = 2'b00;
    pb_raw[1] = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL press_model c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
      if (pb_pulse[1]) begin npulse++; pulse_at = c; end
      if (rise_at < 0 && pb_level[1]) rise_at = c;
      if (c > 40 && fall_at < 0 && !pb_level[1]) fall_at = c - 40;
      if (c == c_lat) begin
        n_checks++;
        if (pb_any !== 1'b1) $display("FAIL press_any got=%b expected=1", pb_any);
        else n_pass++;
      end
      if (c == 40) pb_raw[1] = 1'b0;
    end
    n_checks++;
    if (rise_at != c_lat) $display("FAIL press_latency got=%0d expected=%0d", rise_at, c_lat);
    else n_pass++;
    n_checks++;
    if (npulse != 1 || pulse_at != c_lat)
      $display("FAIL press_pulse count=%0d at=%0d expected count=1 at=%0d", npulse, pulse_at, c_lat);
    else n_pass++;
    n_checks++;
    if (fall_at != c_lat) $display("FAIL release_latency got=%0d expected=%0d", fall_at, c_lat);
    else n_pass++;
  endtask

  task automatic test_edge_modes();
    int q[$];
    int e[$];
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      mode = (pass == 0) ? 2'b10 : 2'b01;
      q.delete();
      e.delete();
      if (pass == 0) e.push_back(c_lat);
      e.push_back(30 + c_lat);
      repeat (4) @(negedge clk_d);
      pb_raw[2] = 1'b1;
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk_d);
        n_checks++;
        if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
          $display("FAIL edge_model m=%0d c=%0d level=%b/%b pulse=%b/%b", mode, c, pb_level, m_level, pb_pulse, m_pulse);
        else n_pass++;
        if (pb_pulse[2]) q.push_back(c);
        if (c == 30) pb_raw[2] = 1'b0;
      end
      ok = (q.size() == e.size());
      for (int k = 0; k < q.size(); k++) if (ok && q[k] != e[k]) ok = 1'b0;
      n_checks++;
      if (!ok)
        $display("FAIL edge_mode%0d pulses=%0d first=%0d expected pulses=%0d first=%0d",
                 mode, q.size(), (q.size() > 0) ? q[0] : -1, e.size(), e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_repeat();
    int q[$];
    int e[$];
    bit ok;
    int fall_at = -1, late = 0;
    mode = 2'b11;
    repeat (4) @(negedge clk_d);
    for (int rnd = 0; rnd < 2; rnd++) begin
      int span = (rnd == 0) ? 60 : 26;
      q.delete();
      e.delete();
      e.push_back(0);
      for (int d = HOLD_CYCLES; d <= span; d += REPEAT_CYCLES) e.push_back(d);
      pb_raw[3] = 1'b1;
      for (int c = 1; c <= c_lat + span; c++) begin
        @(negedge clk_d);
        n_checks++;
        if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
          $display("FAIL repeat_model c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
        else n_pass++;
        if (pb_pulse[3]) q.push_back(c - c_lat);
      end
      ok = (q.size() == e.size());
      for (int k = 0; k < q.size(); k++) if (ok && q[k] != e[k]) ok = 1'b0;
      n_checks++;
      if (!ok)
        $display("FAIL repeat_times round=%0d pulses=%0d last=%0d expected pulses=%0d last=%0d",
                 rnd, q.size(), (q.size() > 0) ? q[q.size()-1] : -1, e.size(), e[e.size()-1]);
      else n_pass++;
      pb_raw[3] = 1'b0;
      fall_at = -1;
      late    = 0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk_d);
        n_checks++;
        if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
          $display("FAIL repeat_release c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
        else n_pass++;
        if (fall_at < 0 && !pb_level[3]) fall_at = c;
        if (fall_at > 0 && pb_pulse[3]) late++;
      end
      n_checks++;
      if (fall_at != c_lat || late != 0)
        $display("FAIL repeat_stop fall_at=%0d late_pulses=%0d expected %0d and 0", fall_at, late, c_lat);
      else n_pass++;
    end
  endtask

  task automatic test_simul_en();
    mode = 2'b00;
    repeat (4) @(negedge clk_d);
    pb_raw[0] = 1'b1;
    pb_raw[3] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_pulse !== ((c == c_lat) ? 4'b1001 : 4'b0000) || pb_pulse !== m_pulse)
        $display("FAIL simul_press c=%0d pulse=%b expected=%b", c, pb_pulse, (c == c_lat) ? 4'b1001 : 4'b0000);
      else n_pass++;
    end
    pb_raw[0] = 1'b0;
    pb_raw[3] = 1'b0;
    en        = 1'b0;
    pb_raw[1] = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_pulse !== '0 || pb_level !== m_level || pb_any !== 1'b0)
        $display("FAIL en_gate c=%0d pulse=%b level=%b/%b expected pulse=0", c, pb_pulse, pb_level, m_level);
      else n_pass++;
      if (c == 12) begin
        n_checks++;
        if (pb_level[1] !== 1'b1) $display("FAIL en_level got=%b expected=1", pb_level[1]);
        else n_pass++;
        en = 1'b1;
      end
    end
    pb_raw[1] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL en_release c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int q[$];
    int e[$];
    bit ok;
    mode = 2'b11;
    repeat (4) @(negedge clk_d);
    pb_raw[2] = 1'b1;
    for (int c = 1; c <= c_lat + 23; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL rstmid_pre c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pb_level !== '0 || pb_pulse !== '0 || pb_any !== 1'b0)
      $display("FAIL rstmid_async level=%b pulse=%b any=%b expected all 0", pb_level, pb_pulse, pb_any);
    else n_pass++;
    @(negedge clk_d);
    rst_n = 1'b1;
    e.push_back(0);
    e.push_back(HOLD_CYCLES);
    e.push_back(HOLD_CYCLES + REPEAT_CYCLES);
    for (int c = 1; c <= c_lat + 26; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL rstmid_post c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
      if (pb_pulse[2]) q.push_back(c - c_lat);
    end
    ok = (q.size() == e.size());
    for (int k = 0; k < q.size(); k++) if (ok && q[k] != e[k]) ok = 1'b0;
    n_checks++;
    if (!ok)
      $display("FAIL rstmid_pulses count=%0d first=%0d expected count=3 offsets 0,%0d,%0d",
               q.size(), (q.size() > 0) ? q[0] : -1, HOLD_CYCLES, HOLD_CYCLES + REPEAT_CYCLES);
    else n_pass++;
    pb_raw[2] = 1'b0;
    repeat (12) @(negedge clk_d);
  endtask

  task automatic test_random();
    int remain[N_CH];
    for (int ch = 0; ch < N_CH; ch++) remain[ch] = $urandom_range(1, 45);
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL random c=%0d mode=%0d en=%b level=%b/%b pulse=%b/%b",
                 c, mode, en, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
      for (int ch = 0; ch < N_CH; ch++) begin
        remain[ch]--;
        if (remain[ch] <= 0) begin
          pb_raw[ch] = ~pb_raw[ch];
          remain[ch] = $urandom_range(1, 45);
        end
      end
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) en = ~en;
    end
    pb_raw = '0;
    en     = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_d);
      n_checks++;
      if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== (|m_pulse))
        $display("FAIL random_flush c=%0d level=%b/%b pulse=%b/%b", c, pb_level, m_level, pb_pulse, m_pulse);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_edge_modes();
    test_repeat();
    test_simul_en();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
